// File: rtl/uart_cfg_pkg.sv
// rtl/uart_cfg_pkg.sv - shared types and helpers for the uart_cfg block
// Holds the parity selection enum, the TX/RX state encodings and the
// parity helper used by both directions.
package uart_cfg_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Words are zero-extended to 16 bits so one helper covers every legal width.
    function automatic logic calc_parity(input logic [15:0] bits, input parity_e mode);
        return (^bits) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-period counter with load and ticks
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : force the count back to 0 on the next edge
//   half_o     : count is at clk_reduction/2 - 1 (mid-bit point)
//   full_o     : count is at clk_reduction - 1 (end of bit period)
module uart_bit_timer #(
    parameter int clk_reduction = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic half_o,
    output logic full_o
);

    localparam int CW = $clog2(clk_reduction);
    localparam logic [CW-1:0] LAST = CW'(clk_reduction - 1);
    localparam logic [CW-1:0] HALF = CW'(clk_reduction / 2 - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign half_o = (cnt_q == HALF);
    assign full_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - configurable UART with stream-style TX and RX handshakes
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   t_data, t_valid, t_ready       : word to transmit and its handshake
//   tx                             : serial output, idle high
//   rx                             : serial input, asynchronous to clk
//   r_data, r_valid, r_ready       : received word and its handshake
//   r_frame_err, r_parity_err,
//   r_overrun                      : status of the word held in r_data
module uart_cfg
    import uart_cfg_pkg::*;
#(
    parameter int      clk_reduction = 64,
    parameter int      word_width    = 8,
    parameter parity_e parity_mode   = PAR_NONE,
    parameter int      stop_bits     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [word_width-1:0] t_data,
    input  logic                  t_valid,
    output logic                  t_ready,
    output logic                  tx,
    input  logic                  rx,
    output logic [word_width-1:0] r_data,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic                  r_frame_err,
    output logic                  r_parity_err,
    output logic                  r_overrun
);

    localparam int BW = $clog2(word_width);
    localparam logic [BW-1:0] LAST_BIT  = BW'(word_width - 1);
    localparam logic          LAST_STOP = (stop_bits == 2);

    // ---------------- transmitter ----------------
    tx_state_e             tx_state_q;
    logic                  tx_q;
    logic                  t_ready_q;
    logic [word_width-1:0] tx_shift_q;
    logic [BW-1:0]         tx_bit_q;
    logic                  tx_par_q;
    logic                  tx_stop_q;
    logic                  tx_load;
    logic                  tx_full;
    logic                  tx_half_unused;

    // The timer is held at zero while idle so the start bit gets a full period.
    assign tx_load = (tx_state_q == TX_IDLE);

    uart_bit_timer #(
        .clk_reduction(clk_reduction)
    ) u_tx_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tx_load),
        .half_o (tx_half_unused),
        .full_o (tx_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            t_ready_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_par_q   <= 1'b0;
            tx_stop_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_q      <= 1'b1;
                    t_ready_q <= 1'b1;
                    if (t_valid && t_ready_q) begin
                        tx_shift_q <= t_data;
                        tx_par_q   <= calc_parity(16'(t_data), parity_mode);
                        tx_q       <= 1'b0;
                        t_ready_q  <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_full) begin
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_full) begin
                        if (tx_bit_q == LAST_BIT) begin
                            if (parity_mode == PAR_NONE) begin
                                tx_q       <= 1'b1;
                                tx_stop_q  <= 1'b0;
                                tx_state_q <= TX_STOP;
                            end else begin
                                tx_q       <= tx_par_q;
                                tx_state_q <= TX_PARITY;
                            end
                        end else begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_bit_q   <= tx_bit_q + BW'(1);
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_full) begin
                        tx_q       <= 1'b1;
                        tx_stop_q  <= 1'b0;
                        tx_state_q <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_full) begin
                        if (tx_stop_q == LAST_STOP) begin
                            t_ready_q  <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_stop_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q       <= 1'b1;
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign t_ready = t_ready_q;

    // ---------------- receiver ----------------
    logic [1:0]            rx_sync_q;
    logic                  rx_prev_q;
    logic                  rx_s;
    rx_state_e             rx_state_q;
    logic [word_width-1:0] rx_shift_q;
    logic [BW-1:0]         rx_bit_q;
    logic                  rx_par_q;
    logic [word_width-1:0] r_data_q;
    logic                  r_valid_q;
    logic                  r_frame_err_q;
    logic                  r_parity_err_q;
    logic                  r_overrun_q;
    logic                  rx_load;
    logic                  rx_half;
    logic                  rx_full;

    assign rx_s = rx_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx};
            rx_prev_q <= rx_s;
        end
    end

    // Reloading at the mid-start sample aligns every later full tick to bit centres.
    assign rx_load = (rx_state_q == RX_IDLE) || ((rx_state_q == RX_START) && rx_half);

    uart_bit_timer #(
        .clk_reduction(clk_reduction)
    ) u_rx_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (rx_load),
        .half_o (rx_half),
        .full_o (rx_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q     <= RX_IDLE;
            rx_shift_q     <= '0;
            rx_bit_q       <= '0;
            rx_par_q       <= 1'b0;
            r_data_q       <= '0;
            r_valid_q      <= 1'b0;
            r_frame_err_q  <= 1'b0;
            r_parity_err_q <= 1'b0;
            r_overrun_q    <= 1'b0;
        end else begin
            // Consumption; a word landing on the same edge overrides below.
            if (r_valid_q && r_ready) begin
                r_valid_q   <= 1'b0;
                r_overrun_q <= 1'b0;
            end
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_half) begin
                        if (rx_s) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_bit_q   <= '0;
                            rx_state_q <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_full) begin
                        rx_shift_q <= {rx_s, rx_shift_q[word_width-1:1]};
                        if (rx_bit_q == LAST_BIT) begin
                            rx_state_q <= (parity_mode == PAR_NONE) ? RX_STOP : RX_PARITY;
                        end else begin
                            rx_bit_q <= rx_bit_q + BW'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_full) begin
                        rx_par_q   <= rx_s;
                        rx_state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Back to idle right at the stop sample so the next start edge
                    // can arrive during the second half of the stop bit.
                    if (rx_full) begin
                        rx_state_q     <= RX_IDLE;
                        r_data_q       <= rx_shift_q;
                        r_frame_err_q  <= !rx_s;
                        r_parity_err_q <= (parity_mode != PAR_NONE) &&
                                          (calc_parity(16'(rx_shift_q), parity_mode) != rx_par_q);
                        r_valid_q      <= 1'b1;
                        r_overrun_q    <= r_valid_q && !r_ready;
                    end
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign r_data       = r_data_q;
    assign r_valid      = r_valid_q;
    assign r_frame_err  = r_frame_err_q;
    assign r_parity_err = r_parity_err_q;
    assign r_overrun    = r_overrun_q;

endmodule

// File: doc/uart_cfg.md
UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 Parameter clk_reduction, default 64: clk cycles per serial bit; SHALL be legal for values >= 4.
REQ-002 Parameter word_width, default 8: data bits per frame; SHALL be legal for 5..9.
REQ-003 Parameter parity_mode, default PAR_NONE: PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-004 Parameter stop_bits, default 1: 1 or 2.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 t_data  in  word_width  word to transmit.
REQ-008 t_valid  in  1  t_data valid.
REQ-009 t_ready  out  1  transmitter can accept a word.
REQ-010 tx  out  1  serial output, idle high.
REQ-011 rx  in  1  serial input, asynchronous to clk.
REQ-012 r_data  out  word_width  last received word.
REQ-013 r_valid  out  1  r_data holds an unconsumed word.
REQ-014 r_ready  in  1  consumer accepts r_data.
REQ-015 r_frame_err, r_parity_err, r_overrun  out  1 each  status of the word in r_data.

Function
REQ-016 The TX handshake SHALL occur on a cycle where t_valid and t_ready are both 1; t_data is captured on that edge.
REQ-017 t_ready SHALL be 0 from the cycle after the handshake until the last stop-bit cycle has completed, then 1.
REQ-018 tx SHALL go low the cycle after the handshake; the frame is start(0), data LSB first, parity bit (if enabled), stop_bits high bits, each held exactly clk_reduction cycles.
REQ-019 The parity bit SHALL be the XOR of the data bits (even) or its inverse (odd).
REQ-020 TX states: IDLE -> START -> DATA -> PARITY (skipped for PAR_NONE) -> STOP -> IDLE; DATA bit index wraps from word_width-1 to exit.
REQ-021 rx SHALL pass through a 2-flop synchroniser (reset value 1) before any use.
REQ-022 RX in IDLE SHALL start a frame on a synchronised 1->0 transition, then sample at clk_reduction/2 cycles (integer division); a sample of 1 there SHALL return to IDLE with no output (false start).
REQ-023 Subsequent data, parity and first stop bit SHALL be sampled at every further clk_reduction cycles; the second stop bit is not checked.
REQ-024 RX SHALL return to IDLE immediately after the stop-bit sample, so a new start edge is detectable during the remaining half bit.
REQ-025 On the stop-bit sample cycle's next edge, r_data, r_frame_err (stop sampled 0) and r_parity_err (mismatch; always 0 for PAR_NONE) SHALL load and r_valid SHALL be 1.
REQ-026 r_valid SHALL clear on an edge where r_valid and r_ready are both 1, unless a new word loads on that same edge, in which case r_valid stays 1 with the new word and r_overrun 0.
REQ-027 A new word loading while r_valid is 1 and not being consumed SHALL overwrite r_data and set r_overrun 1; r_overrun clears on the next consumption.
REQ-028 TX and RX SHALL be fully independent; tx looped to rx SHALL deliver every word unchanged.

Reset
REQ-029 Asserting rst_n low SHALL immediately force tx=1, t_ready=0, r_valid=0, r_data=0, all error flags 0, both FSMs IDLE, synchroniser flops to 1, all counters to 0, aborting any frame in progress.
REQ-030 t_ready SHALL be 1 on the first clk edge after rst_n deasserts.

Structure
REQ-031 Package uart_cfg_pkg SHALL hold the parity_mode enum (PAR_NONE, PAR_EVEN, PAR_ODD) and the TX and RX state enums.
REQ-032 Sub-module uart_bit_timer (counter 0..clk_reduction-1 with load, half-period and full-period tick outputs) SHALL be instantiated once for TX and once for RX.

Verification (clk_reduction=16, word_width=8 unless stated)
REQ-033 PAR_NONE, send 0xA5 -> tx low 1 cycle after handshake, bits 1,0,1,0,0,1,0,1 each 16 cycles, stop high, t_ready back after 160 cycles.
REQ-034 PAR_EVEN, stop_bits=2, loopback 0x07 -> parity bit 1, frame 192 cycles, r_data=0x07, r_parity_err=0, r_frame_err=0.
REQ-035 Drive rx frame 0x3C with stop bit 0 -> r_valid=1, r_data=0x3C, r_frame_err=1.
REQ-036 rx low pulse of 4 cycles -> no r_valid, next valid frame 0x55 received correctly.
REQ-037 Two back-to-back frames 0x11, 0x22 with r_ready=0 -> r_data=0x22, r_overrun=1; r_ready pulse -> r_valid=0, r_overrun=0.
REQ-038 rst_n low mid-TX data bit -> tx=1 same cycle; after release t_ready=1 and next frame 0xF0 correct.
